traffic_light_ped: RTL and testbench
====================================

Name: traffic_light_ped

Overview:
Parametrised four-way traffic-light controller that supersedes the fixed 4-phase controller. It adds configurable phase durations, all-red clearance phases, a latched pedestrian WALK phase and a flashing-red override mode. The block sits between the tick generator, which provides a 1-cycle `tick` strobe, and the lamp drivers. All outputs are Moore outputs decoded from registered state.

Parameters:
- G_TICKS, 5, green duration in ticks, each direction.
- Y_TICKS, 2, yellow duration in ticks, each direction.
- AR_TICKS, 1, all-red clearance duration in ticks.
- WALK_TICKS, 3, pedestrian WALK duration in ticks.
- CNT_W, 4, phase-counter width. Every *_TICKS value must be ≥1 and ≤2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  1-cycle timing strobe; phase time advances only when tick=1.
- ped_req  in  1  pedestrian button; any cycle high sets the request latch.
- flash_en  in  1  level; 1 selects flashing-red override mode.
- ns_g, ns_y, ns_r  out  1 each  north-south lamps.
- ew_g, ew_y, ew_r  out  1 each  east-west lamps.
- walk  out  1  pedestrian WALK lamp.
- ped_pending  out  1  pedestrian request latched, not yet served.
- phase  out  3  current state code (debug/status).

Behaviour:
- States and `phase` codes: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, WALK=6, FLASH=7.
- Lamp decode per state:
  - NS_G: ns_g, ew_r.
  - NS_Y: ns_y, ew_r.
  - AR1, AR2: ns_r, ew_r.
  - EW_G: ew_g, ns_r.
  - EW_Y: ew_y, ns_r.
  - WALK: ns_r, ew_r, walk.
  - FLASH: ns_r = ew_r = flash_ph; all other lamps 0.
  - All unlisted lamps are 0. At most one of g/y/r is high per direction.
- Normal sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→(WALK if ped_pending, else NS_G). WALK→NS_G.
- Phase counter `cnt` (CNT_W bits):
  - Cleared to 0 on every state entry.
  - Increments on each tick while in a state.
  - The state exits on the edge where tick=1 and cnt == DUR-1, where DUR is that state's *_TICKS.
  - With tick=0, state and cnt hold.
- Timing: with tick high every cycle, the state dwells exactly DUR cycles. Outputs change on the clk edge that updates state, with no additional latency.
- Pedestrian latch:
  - ped_pending sets on any edge where ped_req=1 and the current state is not WALK.
  - It clears on the edge that enters WALK; clear has priority over set on that edge.
  - ped_req during WALK is ignored.
  - The latch is held through FLASH.
- Flash override:
  - flash_en=1 forces FLASH on the next edge from any state, regardless of tick or cnt.
  - Entering FLASH clears cnt and flash_ph.
  - In FLASH, flash_ph toggles on each tick.
  - When flash_en=0 in FLASH, the next edge enters AR2 (cnt=0). The normal sequence then resumes.
  - flash_en has priority over every normal transition, including the AR2 → WALK decision.
- Reset (asynchronous, immediate):
  - state=NS_G, cnt=0, ped_pending=0, flash_ph=0.
  - Outputs: ns_g=1, ew_r=1, all other lamps 0, walk=0, phase=0.
  - Reset mid-phase abandons the phase. Any latched request is lost.
- Unreachable state encodings recover to NS_G on the next edge.

Test Plan:
- Reset: assert rst asynchronously between edges → outputs immediately ns_g=1, ew_r=1, phase=0, ped_pending=0; deassert, tick=0 for 10 cycles → phase stays 0.
- Default cycle: tick every cycle, no request → phase dwells 0:5, 1:2, 2:1, 3:5, 4:2, 5:1 cycles, then returns to 0 (16-cycle period); never two greens/yellows simultaneously.
- Pedestrian: 1-cycle ped_req pulse during EW_G → ped_pending=1 until the WALK entry edge; after AR2, phase=6 for 3 ticks with walk=1, ns_r=ew_r=1; then NS_G with ped_pending=0.
- Sparse tick: tick every 4th cycle → NS_G lasts 20 cycles; cnt and state frozen on non-tick cycles.
- Flash: assert flash_en mid EW_G → next edge phase=7, all lamps 0; ns_r/ew_r toggle on each tick; deassert → phase=5 for 1 tick, then NS_G (or WALK if a request was latched before/during flash).
- Reset mid-WALK with ped_pending set during prior phase → immediate NS_G defaults, ped_pending=0, walk=0.

Source files
------------

// File: rtl/traffic_light_ped.sv
// Four-way traffic-light controller with all-red clearance, latched pedestrian
// WALK phase and a flashing-red override; lamps are registered Moore outputs.
module traffic_light_ped #(
  parameter int G_TICKS    = 5,
  parameter int Y_TICKS    = 2,
  parameter int AR_TICKS   = 1,
  parameter int WALK_TICKS = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] G_LAST    = CNT_W'(G_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_TICKS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ped_reg, ped_next;
  logic             flash_ph_reg, flash_ph_next;
  logic [6:0]       lamps_reg;

  function automatic logic [CNT_W-1:0] last_of(input state_t s);
    case (s)
      NS_G, EW_G: last_of = G_LAST;
      NS_Y, EW_Y: last_of = Y_LAST;
      AR1, AR2:   last_of = AR_LAST;
      default:    last_of = WALK_LAST;
    endcase
  endfunction

  function automatic state_t seq_next(input state_t s, input logic ped);
    case (s)
      NS_G:    seq_next = NS_Y;
      NS_Y:    seq_next = AR1;
      AR1:     seq_next = EW_G;
      EW_G:    seq_next = EW_Y;
      EW_Y:    seq_next = AR2;
      AR2:     seq_next = ped ? WALK : NS_G;
      default: seq_next = NS_G;
    endcase
  endfunction

  // Lamp order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  function automatic logic [6:0] decode(input state_t s, input logic fph);
    case (s)
      NS_G:    decode = 7'b100_001_0;
      NS_Y:    decode = 7'b010_001_0;
      AR1:     decode = 7'b001_001_0;
      EW_G:    decode = 7'b001_100_0;
      EW_Y:    decode = 7'b001_010_0;
      AR2:     decode = 7'b001_001_0;
      WALK:    decode = 7'b001_001_1;
      FLASH:   decode = {2'b00, fph, 2'b00, fph, 1'b0};
      default: decode = 7'b100_001_0;
    endcase
  endfunction

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    flash_ph_next = flash_ph_reg;
    ped_next      = ped_reg;
    // Override beats every normal transition, including the AR2 walk decision.
    if (flash_en) begin
      state_next = FLASH;
      cnt_next   = '0;
      if (state_reg != FLASH)
        flash_ph_next = 1'b0;
      else if (tick)
        flash_ph_next = ~flash_ph_reg;
    end else if (state_reg == FLASH) begin
      state_next = AR2;
      cnt_next   = '0;
    end else if (tick) begin
      if (cnt_reg == last_of(state_reg)) begin
        state_next = seq_next(state_reg, ped_reg);
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
    if (state_next == WALK && state_reg != WALK)
      ped_next = 1'b0;
    else if (ped_req && state_reg != WALK)
      ped_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= NS_G;
      cnt_reg      <= '0;
      ped_reg      <= 1'b0;
      flash_ph_reg <= 1'b0;
      lamps_reg    <= 7'b100_001_0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ped_reg      <= ped_next;
      flash_ph_reg <= flash_ph_next;
      lamps_reg    <= decode(state_next, flash_ph_next);
    end
  end

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} = lamps_reg;
  assign ped_pending = ped_reg;
  assign phase       = state_reg;

endmodule

// File: tb/tb_traffic_light_ped.sv
// Bench for traffic_light_ped: a phase/elapsed-tick reference model checked every
// cycle, plus directed scenarios with hand-computed dwell times and lamp values.
module tb_traffic_light_ped;

  localparam int G_T = 5, Y_T = 2, AR_T = 1, W_T = 3;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, ped_req = 1'b0, flash_en = 1'b0;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_ped #(
    .G_TICKS(G_T), .Y_TICKS(Y_T), .AR_TICKS(AR_T), .WALK_TICKS(W_T), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index, ticks elapsed in the phase, request flag, flash phase.
  int m_ph = 0, m_cnt = 0;
  bit m_ped = 1'b0, m_fph = 1'b0;

  function automatic int dur_of(input int p);
    case (p)
      0, 3:    return G_T;
      1, 4:    return Y_T;
      2, 5:    return AR_T;
      default: return W_T;
    endcase
  endfunction

  wire m_exit = tick && (m_cnt + 1 == dur_of(m_ph));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_cnt <= 0; m_ped <= 1'b0; m_fph <= 1'b0;
    end else begin
      if (flash_en) begin
        m_ph  <= 7;
        m_cnt <= 0;
        m_fph <= (m_ph != 7) ? 1'b0 : (tick ? ~m_fph : m_fph);
      end else if (m_ph == 7) begin
        m_ph <= 5; m_cnt <= 0;
      end else if (m_exit) begin
        m_ph  <= (m_ph == 5) ? (m_ped ? 6 : 0) : ((m_ph == 6) ? 0 : m_ph + 1);
        m_cnt <= 0;
      end else if (tick) begin
        m_cnt <= m_cnt + 1;
      end
      if (!flash_en && m_ph == 5 && m_exit && m_ped) m_ped <= 1'b0;
      else if (ped_req && m_ph != 6)                 m_ped <= 1'b1;
    end
  end

  function automatic logic [10:0] exp_vec(input int p, input bit fph, input bit ped);
    logic r_ns, r_ew;
    r_ns = (p >= 2 && p <= 6) || (p == 7 && fph);
    r_ew = (p == 0 || p == 1 || p == 2 || p == 5 || p == 6) || (p == 7 && fph);
    return {3'(p), p == 0, p == 1, r_ns, p == 3, p == 4, r_ew, p == 6, ped};
  endfunction

  wire [10:0] dut_vec = {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending};

  always @(posedge clk) begin
    #1;
    if (!rst) check("cycle", int'(dut_vec), int'(exp_vec(m_ph, m_fph, m_ped)));
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while (int'(phase) != p && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", int'(phase), p);
  endtask

  task automatic dwell(input int p, input int exp, input string name);
    int n = 0;
    while (int'(phase) == p && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp);
  endtask

  task automatic pulse_ped();
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
  endtask

  initial begin
    int dw[6];
    int i;
    dw = '{5, 2, 1, 5, 2, 1};

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_ns_g", int'(ns_g), 1);
    check("rst_ew_r", int'(ew_r), 1);
    check("rst_ped", int'(ped_pending), 0);
    @(negedge clk); rst = 1'b0;

    repeat (10) @(negedge clk);
    check("no_tick_hold", int'(phase), 0);

    // Default cycle, tick every cycle.
    tick = 1'b1;
    for (int k = 0; k < 6; k++) dwell(k, dw[k], $sformatf("dwell_%0d", k));
    check("cycle_wrap", int'(phase), 0);

    // Pedestrian request during EW_G.
    wait_phase(3);
    pulse_ped();
    check("ped_latched", int'(ped_pending), 1);
    wait_phase(6);
    check("walk_lamp", int'(walk), 1);
    dwell(6, 3, "walk_dwell");
    check("after_walk_ph", int'(phase), 0);
    check("after_walk_ped", int'(ped_pending), 0);

    // Sparse tick: every 4th cycle.
    i = 0;
    while (phase == 3'd0 && i < 100) begin
      tick = (i % 4 == 3);
      @(negedge clk);
      i++;
    end
    check("sparse_ns_g", i, 20);
    tick = 1'b1;

    // Flash override mid EW_G, request arrives during flash.
    wait_phase(3);
    repeat (2) @(negedge clk);
    flash_en = 1'b1;
    @(negedge clk);
    check("flash_phase", int'(phase), 7);
    check("flash_dark", int'({ns_r, ew_r}), 0);
    ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    check("flash_on", int'({ns_r, ew_r}), 3);
    check("flash_ped", int'(ped_pending), 1);
    @(negedge clk);
    check("flash_off", int'(ns_r), 0);
    flash_en = 1'b0;
    @(negedge clk);
    check("flash_exit_ar2", int'(phase), 5);
    @(negedge clk);
    check("flash_to_walk", int'(phase), 6);
    wait_phase(0);

    // Reset while a request is latched loses it.
    wait_phase(3);
    pulse_ped();
    wait_phase(4);
    @(negedge clk); #2 rst = 1'b1; #1;
    check("rst_ped_lost", int'(ped_pending), 0);
    check("rst_mid_ph", int'(phase), 0);
    check("rst_mid_ew_y", int'(ew_y), 0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-WALK.
    wait_phase(3);
    pulse_ped();
    wait_phase(6);
    @(negedge clk); #2 rst = 1'b1; #1;
    check("rstw_phase", int'(phase), 0);
    check("rstw_walk", int'(walk), 0);
    check("rstw_ns_g", int'(ns_g), 1);
    check("rstw_ew_r", int'(ew_r), 1);
    check("rstw_ped", int'(ped_pending), 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
